// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin arbiter that shares one 2:1 mux between two streaming requesters A and B.
// Optional per-grant beat bound: define MUX_ARB_BURST_LIMIT_EN (limit = MAX_BEATS).
module mux2to1_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              valid_a,
    input  logic              valid_b,
    input  logic              last_a,
    input  logic              last_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              ready_a,
    output logic              ready_b,
    output logic              sel,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    input  logic              y_ready,
    output logic              busy
);

    // One-hot grant encoding so gnt_a/gnt_b come straight from flops.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   ptr, ptr_nxt;      // 0: A wins a tie, 1: B wins a tie
    logic   sel_nxt;
    logic   beat_acc;
    logic   req_cur;
    logic   last_cur;
    logic   limit_hit;
    logic   txn_end;

    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("MAX_BEATS must be at least 1");
    end

    assign gnt_a    = state[0];
    assign gnt_b    = state[1];
    assign busy     = gnt_a | gnt_b;
    assign ready_a  = gnt_a & y_ready;
    assign ready_b  = gnt_b & y_ready;
    assign y_valid  = (gnt_a & valid_a) | (gnt_b & valid_b);
    assign y_data   = sel ? data_b : data_a;
    assign beat_acc = y_valid & y_ready;

    assign req_cur  = gnt_a ? req_a  : req_b;
    assign last_cur = gnt_a ? last_a : last_b;
    assign txn_end  = busy & (~req_cur | (beat_acc & (last_cur | limit_hit)));

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt;

    // Held at zero while idle, so every grant starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (!busy) begin
            beat_cnt <= '0;
        end else if (beat_acc) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign limit_hit = (beat_cnt == CNT_W'(MAX_BEATS - 1));
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || !ptr)) begin
                    state_nxt = GNT_A;
                    sel_nxt   = 1'b0;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                    sel_nxt   = 1'b1;
                end
            end
            GNT_A: begin
                if (txn_end) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b1;
                end
            end
            GNT_B: begin
                if (txn_end) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Self-checking bench for mux2to1_rr_arbiter: directed scenarios plus randomized
// producers, all compared cycle by cycle against a transaction-level reference model.
module tb_mux2to1_rr_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_a, req_b, valid_a, valid_b, last_a, last_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              gnt_a, gnt_b, ready_a, ready_b, sel, y_valid, busy;
    logic [DATA_W-1:0] y_data;
    logic              y_ready;

    mux2to1_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .valid_a(valid_a), .valid_b(valid_b),
        .last_a(last_a), .last_b(last_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .ready_a(ready_a), .ready_b(ready_b),
        .sel(sel), .y_valid(y_valid), .y_data(y_data),
        .y_ready(y_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the mux (-1 none, 0 A, 1 B), whose turn a tie is,
    // the select value and beats accepted in the current grant.
    int owner, turn, sel_m, cnt_m;
    bit acc_a_m, acc_b_m;

    // Producer state: pending transaction and beats remaining.
    bit pend_a, pend_b;
    int rem_a, rem_b;
    bit rand_mode, refill, yr;
    int refill_beats;
    int cyc;
    bit was_busy;
    int glog[$];
    int glog_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        turn  = 0;
        sel_m = 0;
        cnt_m = 0;
    endtask

    task automatic step();
        int  n_owner, n_turn, n_sel, n_cnt;
        bit  r_o, l_o, acc, done;
        logic [DATA_W-1:0] e_data;
        #1;
        e_data = (sel_m != 0) ? data_b : data_a;
        check("gnt_a",   32'(gnt_a),   32'(owner == 0));
        check("gnt_b",   32'(gnt_b),   32'(owner == 1));
        check("busy",    32'(busy),    32'(owner >= 0));
        check("sel",     32'(sel),     32'(sel_m));
        check("y_valid", 32'(y_valid), 32'((owner == 0 && valid_a) || (owner == 1 && valid_b)));
        check("y_data",  32'(y_data),  32'(e_data));
        check("ready_a", 32'(ready_a), 32'(owner == 0 && y_ready));
        check("ready_b", 32'(ready_b), 32'(owner == 1 && y_ready));
        acc_a_m = (owner == 0) && y_ready && valid_a;
        acc_b_m = (owner == 1) && y_ready && valid_b;

        n_owner = owner; n_turn = turn; n_sel = sel_m; n_cnt = cnt_m;
        if (owner < 0) begin
            if (req_a && req_b) n_owner = turn;
            else if (req_a)     n_owner = 0;
            else if (req_b)     n_owner = 1;
            if (n_owner >= 0) begin
                n_sel = n_owner;
                n_cnt = 0;
            end
        end else begin
            r_o   = (owner == 0) ? req_a  : req_b;
            l_o   = (owner == 0) ? last_a : last_b;
            acc   = acc_a_m || acc_b_m;
            n_cnt = cnt_m + (acc ? 1 : 0);
            done  = !r_o || (acc && l_o);
`ifdef MUX_ARB_BURST_LIMIT_EN
            if (n_cnt == MAX_BEATS) done = 1'b1;
`endif
            if (done) begin
                n_turn  = 1 - owner;
                n_owner = -1;
            end
        end
        @(posedge clk);
        owner = n_owner; turn = n_turn; sel_m = n_sel; cnt_m = n_cnt;
        @(negedge clk);
    endtask

    task automatic drive();
        if (rand_mode) begin
            if (!pend_a && $urandom_range(0, 3) == 0) begin
                pend_a = 1'b1; rem_a = $urandom_range(1, 6);
            end else if (pend_a && $urandom_range(0, 39) == 0) begin
                pend_a = 1'b0;
            end
            if (!pend_b && $urandom_range(0, 3) == 0) begin
                pend_b = 1'b1; rem_b = $urandom_range(1, 6);
            end else if (pend_b && $urandom_range(0, 39) == 0) begin
                pend_b = 1'b0;
            end
            valid_a = pend_a ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            valid_b = pend_b ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            y_ready = ($urandom_range(0, 3) != 0);
        end else begin
            valid_a = pend_a;
            valid_b = pend_b;
            y_ready = yr;
        end
        req_a  = pend_a;
        req_b  = pend_b;
        last_a = pend_a ? (rem_a == 1) : 1'($urandom_range(0, 1));
        last_b = pend_b ? (rem_b == 1) : 1'($urandom_range(0, 1));
        data_a = DATA_W'($urandom);
        data_b = DATA_W'($urandom);
    endtask

    task automatic step_upd();
        step();
        cyc++;
        if (acc_a_m && pend_a) begin
            if (rem_a == 1) begin pend_a = refill; rem_a = refill_beats; end
            else rem_a--;
        end
        if (acc_b_m && pend_b) begin
            if (rem_b == 1) begin pend_b = refill; rem_b = refill_beats; end
            else rem_b--;
        end
        if ((gnt_a || gnt_b) && !was_busy) begin
            glog.push_back(gnt_b ? 1 : 0);
            glog_t.push_back(cyc);
        end
        was_busy = gnt_a || gnt_b;
    endtask

    task automatic cycle();
        drive();
        step_upd();
    endtask

    task automatic do_reset();
        pend_a = 1'b0; pend_b = 1'b0;
        req_a = 1'b0; req_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        was_busy = 1'b0;
        glog.delete();
        glog_t.delete();
    endtask

    initial begin
        cyc = 0; rand_mode = 1'b0; refill = 1'b0; refill_beats = 0; yr = 1'b1;
        pend_a = 1'b0; pend_b = 1'b0; rem_a = 0; rem_b = 0; was_busy = 1'b0;
        req_a = 1'b0; req_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        last_a = 1'b0; last_b = 1'b0; data_a = '0; data_b = '0; y_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt_a",   32'(gnt_a),   32'd0);
        check("rst_gnt_b",   32'(gnt_b),   32'd0);
        check("rst_sel",     32'(sel),     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_ready_a", 32'(ready_a | ready_b), 32'd0);
        rst = 1'b0;

        // Single one-beat transaction from A.
        pend_a = 1'b1; rem_a = 1;
        drive(); data_a = 8'h3C; step_upd();
        check("t1_gnt_a",  32'(gnt_a),  32'd1);
        check("t1_sel",    32'(sel),    32'd0);
        drive(); data_a = 8'h3C;
        #1 check("t1_y_data", 32'(y_data), 32'h3C);
        step_upd();
        check("t1_gnt_drop", 32'(gnt_a), 32'd0);
        pend_a = 1'b1; rem_a = 1; pend_b = 1'b1; rem_b = 1;
        cycle();
        check("t1_ptr_b", 32'(gnt_b), 32'd1);
        repeat (5) cycle();

        // Reset in the middle of a B grant.
        pend_b = 1'b1; rem_b = 4;
        cycle();
        cycle();
        check("t5_pre_gnt_b", 32'(gnt_b), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_gnt_b", 32'(gnt_b),   32'd0);
        check("t5_busy",  32'(busy),    32'd0);
        check("t5_yv",    32'(y_valid), 32'd0);
        model_reset();
        pend_a = 1'b0; pend_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        was_busy = 1'b0; glog.delete(); glog_t.delete();

        // Both requesting continuously with 2-beat transactions.
        pend_a = 1'b1; rem_a = 2; pend_b = 1'b1; rem_b = 2;
        refill = 1'b1; refill_beats = 2;
        repeat (13) cycle();
        refill = 1'b0;
        check("t2_ngrants", 32'(glog.size() >= 4), 32'd1);
        if (glog.size() >= 4) begin
            check("t2_g0", 32'(glog[0]), 32'd0);
            check("t2_g1", 32'(glog[1]), 32'd1);
            check("t2_g2", 32'(glog[2]), 32'd0);
            check("t2_g3", 32'(glog[3]), 32'd1);
            check("t2_gap", 32'(glog_t[1] - glog_t[0]), 32'd3);
        end
        pend_a = 1'b0; pend_b = 1'b0;
        repeat (3) cycle();

        // Downstream stall while B is granted.
        pend_b = 1'b1; rem_b = 2; yr = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_ready_b", 32'(ready_b), 32'd0);
            check("t3_y_data",  32'(y_data),  32'(data_b));
            check("t3_rem",     32'(rem_b),   32'd2);
        end
        yr = 1'b1;
        repeat (2) cycle();
        check("t3_done", 32'(pend_b), 32'd0);
        cycle();
        check("t3_idle", 32'(busy), 32'd0);

        // A aborts after one of four beats while B waits.
        do_reset();
        pend_a = 1'b1; rem_a = 4;
        cycle();
        pend_b = 1'b1; rem_b = 1;
        cycle();
        check("t4_rem_a", 32'(rem_a), 32'd3);
        pend_a = 1'b0;
        cycle();
        check("t4_abort", 32'(gnt_a), 32'd0);
        pend_a = 1'b1; rem_a = 1;
        cycle();
        check("t4_gnt_b", 32'(gnt_b), 32'd1);
        repeat (5) cycle();

        // Six-beat A against two-beat B.
        do_reset();
        pend_a = 1'b1; rem_a = 6; pend_b = 1'b1; rem_b = 2;
        repeat (16) cycle();
        check("t6_done", 32'(pend_a | pend_b), 32'd0);
`ifdef MUX_ARB_BURST_LIMIT_EN
        check("t6_ngrants", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            check("t6_g0", 32'(glog[0]), 32'd0);
            check("t6_g1", 32'(glog[1]), 32'd1);
            check("t6_g2", 32'(glog[2]), 32'd0);
        end
`else
        check("t6_ngrants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("t6_g0", 32'(glog[0]), 32'd0);
            check("t6_g1", 32'(glog[1]), 32'd1);
        end
`endif

        // Randomized producers and downstream back-pressure.
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
